fir_block_filter: RTL and testbench
===================================

Name: fir_block_filter

Overview:
- Parametrised successor to the fixed 16-bit, 8-tap-per-word FIR block engine.
- Filters a block of SAMPLES_NUM new samples per start using a run-time-loadable coefficient bank.
- The sample history carries across blocks, so consecutive blocks form one continuous stream.
- Output stage has configurable rounding shift, saturation and a saturation flag. Sits between the sample framer and the output formatter.

Parameters:
SAMPLE_WIDTH, 16, signed sample and coefficient width
TAPS, 8, filter length; must be a multiple of LANES
LANES, 4, taps processed per cycle per output lane (G = TAPS/LANES groups)
SAMPLES_NUM, 4, samples per block, 1..8
OUT_WIDTH, 32, signed output width, <= ACC_WIDTH
OUT_SHIFT, 0, arithmetic right shift applied before saturation
(derived) ACC_WIDTH = 2*SAMPLE_WIDTH + clog2(TAPS)

Ports:
clkIn  in  1  clock, rising edge
resetIn  in  1  synchronous active-high reset
startIn  in  1  start a block; accepted when busyOut=0
dataIn  in  SAMPLE_WIDTH*SAMPLES_NUM  block; lane k in bits [SW*(k+1)-1:SW*k]; lane 0 is oldest
coefWrIn  in  1  coefficient write strobe
coefAddrIn  in  clog2(TAPS)  tap index j
coefDataIn  in  SAMPLE_WIDTH  signed coefficient c[j]
clearHistIn  in  1  zero the sample history
busyOut  out  1  block in progress
doneOut  out  1  one-cycle pulse; dataOut and satOut are valid from this cycle
coefRejectOut  out  1  one-cycle pulse: a write arrived while busy and was dropped
satOut  out  1  at least one lane saturated in the last block
dataOut  out  OUT_WIDTH*SAMPLES_NUM  lane k = y_k, same lane packing as dataIn

Behaviour:
- Reset is synchronous, active-high and overrides everything, including an operation in progress, which it aborts.
  - All outputs go to 0: busyOut, doneOut, coefRejectOut, satOut, dataOut.
  - History, accumulators and all coefficients go to 0.
- Function: y_k = sum over j=0..TAPS-1 of c[j]*x(k-j).
  - x(m) for m<0 is taken from the previous blocks' history (TAPS-1 samples retained, newest last).
- Accept edge E0 requires startIn=1 and busyOut=0.
  - Latch dataIn, clear all SAMPLES_NUM accumulators, set busyOut=1.
  - startIn while busyOut=1 is ignored.
- Edges E1..EG: group g accumulates taps g*LANES..g*LANES+LANES-1 for every lane.
  - Products are 2*SW signed, summed at ACC_WIDTH, so there is no overflow.
- Edge E(G+1):
  - Register dataOut per lane as sat(round(acc)).
  - Set satOut = OR of lane saturations.
  - doneOut=1, busyOut=0.
  - Shift the SAMPLES_NUM new samples into history.
- Edge E(G+2): doneOut=0. startIn sampled high here is accepted, so throughput is one block per G+2 cycles.
- Rounding: if OUT_SHIFT>0, compute (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (round half up); otherwise acc unchanged.
- Saturation clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- dataOut and satOut hold their values until the next done or reset.
- State machine: IDLE -> (start) ACCUM (G cycles, group counter 0..G-1, wraps to 0) -> OUTPUT (1 cycle) -> IDLE. doneOut is high in the cycle after OUTPUT.
- Coefficient writes:
  - coefWrIn in IDLE writes c[coefAddrIn] at that edge.
  - If startIn and coefWrIn are both high at the same IDLE edge, the write applies first and the block uses the new coefficient.
  - coefWrIn while busyOut=1 is dropped and pulses coefRejectOut for 1 cycle.
- clearHistIn:
  - In IDLE, zeroes history at that edge.
  - Coincident with an accepted start, history is zeroed before the block is computed.
  - While busyOut=1 it is ignored.

Test Plan:
Defaults, c[j]=j+1; dataIn lanes {1,0,0,0} (lane0=1), start -> doneOut at E3 (G=2), dataOut {1,2,3,4}, satOut=0; next block all-zero -> {5,6,7,8}; next zero block -> {0,0,0,0}.
OUT_WIDTH=16, all c=0x7FFF, all samples 0x7FFF for two blocks -> second block every lane 0x7FFF, satOut=1; c=0x8000 with same samples -> every lane 0x8000, satOut=1.
OUT_SHIFT=1, c[0]=1, other coefs 0, lanes {3,-3,5,-5} -> dataOut {2,-1,3,-2}.
Start a block, coefWrIn at E1 (addr 0, data 9) -> coefRejectOut pulses 1 cycle; rerun impulse -> lane0 still 1.
startIn held continuously -> done every 4 cycles, busyOut low exactly 1 cycle between blocks; resetIn asserted at E1 -> next cycle busyOut=0, dataOut=0, all coefs 0, next impulse block gives {0,0,0,0}.
Impulse block, then clearHistIn, then zero block -> {0,0,0,0}, not {5,6,7,8}.

Source files
------------

// File: rtl/fir_block_filter_if.sv
// Block bus between the sample framer, the FIR block engine and the output formatter.
// The framer side is the master; the filter engine is the slave.
interface fir_block_filter_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int TAPS         = 8,
  parameter int SAMPLES_NUM  = 4,
  parameter int OUT_WIDTH    = 32
);
  logic                                startIn;
  logic [SAMPLE_WIDTH*SAMPLES_NUM-1:0] dataIn;
  logic                                coefWrIn;
  logic [$clog2(TAPS)-1:0]             coefAddrIn;
  logic [SAMPLE_WIDTH-1:0]             coefDataIn;
  logic                                clearHistIn;
  logic                                busyOut;
  logic                                doneOut;
  logic                                coefRejectOut;
  logic                                satOut;
  logic [OUT_WIDTH*SAMPLES_NUM-1:0]    dataOut;

  modport master (
    output startIn, dataIn, coefWrIn, coefAddrIn, coefDataIn, clearHistIn,
    input  busyOut, doneOut, coefRejectOut, satOut, dataOut
  );

  modport slave (
    input  startIn, dataIn, coefWrIn, coefAddrIn, coefDataIn, clearHistIn,
    output busyOut, doneOut, coefRejectOut, satOut, dataOut
  );
endinterface

// File: rtl/fir_block_filter.sv
// Block FIR engine: SAMPLES_NUM outputs per start, LANES taps per cycle per lane,
// history carried across blocks, rounding shift and saturation on the output stage.
module fir_block_filter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int TAPS         = 8,
  parameter int LANES        = 4,
  parameter int SAMPLES_NUM  = 4,
  parameter int OUT_WIDTH    = 32,
  parameter int OUT_SHIFT    = 0
) (
  input logic               clkIn,
  input logic               resetIn,
  fir_block_filter_if.slave bus
);
  localparam int ACC_WIDTH = 2*SAMPLE_WIDTH + $clog2(TAPS);
  localparam int EXT_WIDTH = ACC_WIDTH + 1;
  localparam int GROUPS    = TAPS / LANES;
  localparam int GW        = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int HIST      = TAPS - 1;
  localparam int WIN       = HIST + SAMPLES_NUM;
  localparam int HALF_POS  = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic signed [EXT_WIDTH-1:0] ROUND_HALF =
    (OUT_SHIFT > 0) ? (EXT_WIDTH'(1'b1) << HALF_POS) : '0;
  localparam logic signed [EXT_WIDTH-1:0] OUT_MAX =
    {{(EXT_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  logic [1:0]                        stateR;
  logic [GW-1:0]                     groupCntR;
  logic signed [SAMPLE_WIDTH-1:0]    coefR  [TAPS];
  logic signed [SAMPLE_WIDTH-1:0]    histR  [HIST];
  logic signed [SAMPLE_WIDTH-1:0]    blockR [SAMPLES_NUM];
  logic signed [ACC_WIDTH-1:0]       accR   [SAMPLES_NUM];
  logic signed [SAMPLE_WIDTH-1:0]    winS   [WIN];
  logic signed [ACC_WIDTH-1:0]       groupSumS [SAMPLES_NUM];
  logic [OUT_WIDTH:0]                laneResS  [SAMPLES_NUM];
  logic [SAMPLES_NUM-1:0]            laneSatS;
  logic                              busyR;
  logic                              doneR;
  logic                              rejectR;
  logic                              satR;
  logic [OUT_WIDTH*SAMPLES_NUM-1:0]  dataR;

  // Round half up by OUT_SHIFT, then clamp; MSB of the result flags a clamp.
  function automatic logic [OUT_WIDTH:0] roundSat(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [EXT_WIDTH-1:0] wide;
    logic signed [EXT_WIDTH-1:0] shifted;
    wide    = {acc[ACC_WIDTH-1], acc};
    shifted = (wide + ROUND_HALF) >>> OUT_SHIFT;
    if (shifted > OUT_MAX) begin
      roundSat = {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
    end else if (shifted < OUT_MIN) begin
      roundSat = {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
    end else begin
      roundSat = {1'b0, shifted[OUT_WIDTH-1:0]};
    end
  endfunction

  // Sliding window: retained history (oldest first) followed by the latched block.
  always_comb begin
    for (int i = 0; i < HIST; i++) begin
      winS[i] = histR[i];
    end
    for (int i = 0; i < SAMPLES_NUM; i++) begin
      winS[HIST+i] = blockR[i];
    end
  end

  // Partial sum of the current tap group for every lane; x(k-j) sits at winS[k-j+HIST].
  always_comb begin
    int tap;
    logic signed [2*SAMPLE_WIDTH-1:0] prod;
    tap  = 0;
    prod = '0;
    for (int k = 0; k < SAMPLES_NUM; k++) begin
      groupSumS[k] = '0;
      for (int l = 0; l < LANES; l++) begin
        tap          = int'(groupCntR) * LANES + l;
        prod         = coefR[tap] * winS[k - tap + HIST];
        groupSumS[k] = groupSumS[k] + ACC_WIDTH'(prod);
      end
    end
  end

  // Output shaping per lane.
  always_comb begin
    for (int k = 0; k < SAMPLES_NUM; k++) begin
      laneResS[k] = roundSat(accR[k]);
      laneSatS[k] = laneResS[k][OUT_WIDTH];
    end
  end

  // Control FSM, coefficient bank, history and registered outputs.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      stateR    <= IDLE;
      groupCntR <= '0;
      busyR     <= 1'b0;
      doneR     <= 1'b0;
      rejectR   <= 1'b0;
      satR      <= 1'b0;
      dataR     <= '0;
      for (int j = 0; j < TAPS; j++) coefR[j] <= '0;
      for (int i = 0; i < HIST; i++) histR[i] <= '0;
      for (int k = 0; k < SAMPLES_NUM; k++) begin
        blockR[k] <= '0;
        accR[k]   <= '0;
      end
    end else begin
      doneR   <= 1'b0;
      rejectR <= 1'b0;
      case (stateR)
        IDLE: begin
          if (bus.coefWrIn) begin
            coefR[bus.coefAddrIn] <= bus.coefDataIn;
          end
          if (bus.clearHistIn) begin
            for (int i = 0; i < HIST; i++) histR[i] <= '0;
          end
          if (bus.startIn) begin
            for (int k = 0; k < SAMPLES_NUM; k++) begin
              blockR[k] <= bus.dataIn[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
              accR[k]   <= '0;
            end
            groupCntR <= '0;
            busyR     <= 1'b1;
            stateR    <= ACCUM;
          end
        end
        ACCUM: begin
          rejectR <= bus.coefWrIn;
          for (int k = 0; k < SAMPLES_NUM; k++) accR[k] <= accR[k] + groupSumS[k];
          if (groupCntR == GW'(GROUPS - 1)) begin
            groupCntR <= '0;
            stateR    <= OUTPUT;
          end else begin
            groupCntR <= groupCntR + GW'(1'b1);
          end
        end
        OUTPUT: begin
          rejectR <= bus.coefWrIn;
          for (int k = 0; k < SAMPLES_NUM; k++) begin
            dataR[k*OUT_WIDTH +: OUT_WIDTH] <= laneResS[k][OUT_WIDTH-1:0];
          end
          satR  <= |laneSatS;
          doneR <= 1'b1;
          busyR <= 1'b0;
          // The newest TAPS-1 samples of the window become the history.
          for (int i = 0; i < HIST; i++) histR[i] <= winS[i+SAMPLES_NUM];
          stateR <= IDLE;
        end
        default: begin
          busyR     <= 1'b0;
          groupCntR <= '0;
          stateR    <= IDLE;
        end
      endcase
    end
  end

  assign bus.busyOut       = busyR;
  assign bus.doneOut       = doneR;
  assign bus.coefRejectOut = rejectR;
  assign bus.satOut        = satR;
  assign bus.dataOut       = dataR;
endmodule

// File: tb/tb_fir_block_filter.sv
// Self-checking bench: three filter configurations share one stimulus stream and are
// compared against a sample-stream convolution model.
module tb_fir_block_filter;
  localparam int SW    = 16;
  localparam int TAPS  = 8;
  localparam int LANES = 4;
  localparam int SN    = 4;
  localparam int G     = TAPS / LANES;

  logic clk = 1'b0;
  logic rst;
  logic startIn, coefWrIn, clearHistIn;
  logic [SW*SN-1:0] dataIn;
  logic [2:0]       coefAddrIn;
  logic [SW-1:0]    coefDataIn;

  always #5 clk = ~clk;

  fir_block_filter_if #(.SAMPLE_WIDTH(SW), .TAPS(TAPS), .SAMPLES_NUM(SN), .OUT_WIDTH(32)) ifA ();
  fir_block_filter_if #(.SAMPLE_WIDTH(SW), .TAPS(TAPS), .SAMPLES_NUM(SN), .OUT_WIDTH(16)) ifB ();
  fir_block_filter_if #(.SAMPLE_WIDTH(SW), .TAPS(TAPS), .SAMPLES_NUM(SN), .OUT_WIDTH(32)) ifC ();

  assign ifA.startIn = startIn;     assign ifB.startIn = startIn;     assign ifC.startIn = startIn;
  assign ifA.dataIn = dataIn;       assign ifB.dataIn = dataIn;       assign ifC.dataIn = dataIn;
  assign ifA.coefWrIn = coefWrIn;   assign ifB.coefWrIn = coefWrIn;   assign ifC.coefWrIn = coefWrIn;
  assign ifA.coefAddrIn = coefAddrIn; assign ifB.coefAddrIn = coefAddrIn; assign ifC.coefAddrIn = coefAddrIn;
  assign ifA.coefDataIn = coefDataIn; assign ifB.coefDataIn = coefDataIn; assign ifC.coefDataIn = coefDataIn;
  assign ifA.clearHistIn = clearHistIn; assign ifB.clearHistIn = clearHistIn; assign ifC.clearHistIn = clearHistIn;

  fir_block_filter #(.SAMPLE_WIDTH(SW), .TAPS(TAPS), .LANES(LANES), .SAMPLES_NUM(SN),
                     .OUT_WIDTH(32), .OUT_SHIFT(0)) dutA (.clkIn(clk), .resetIn(rst), .bus(ifA));
  fir_block_filter #(.SAMPLE_WIDTH(SW), .TAPS(TAPS), .LANES(LANES), .SAMPLES_NUM(SN),
                     .OUT_WIDTH(16), .OUT_SHIFT(0)) dutB (.clkIn(clk), .resetIn(rst), .bus(ifB));
  fir_block_filter #(.SAMPLE_WIDTH(SW), .TAPS(TAPS), .LANES(LANES), .SAMPLES_NUM(SN),
                     .OUT_WIDTH(32), .OUT_SHIFT(1)) dutC (.clkIn(clk), .resetIn(rst), .bus(ifC));

  int checks = 0;
  int passes = 0;

  // Reference model: coefficient bank, last TAPS-1 stream samples, per-lane exact sums.
  int     mc [TAPS];
  int     mh [$];
  int     blk [SN];
  longint expAcc [SN];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void modelReset();
    mh = {};
    for (int i = 0; i < TAPS-1; i++) mh.push_back(0);
    for (int j = 0; j < TAPS; j++) mc[j] = 0;
  endfunction

  // y_k = sum_j c[j]*x(k-j); negative indices reach back into the retained stream.
  function automatic void modelBlock(input bit clr);
    longint acc;
    int     m;
    int     x;
    if (clr) foreach (mh[i]) mh[i] = 0;
    for (int k = 0; k < SN; k++) begin
      acc = 0;
      for (int j = 0; j < TAPS; j++) begin
        m   = k - j;
        x   = (m >= 0) ? blk[m] : mh[TAPS-1+m];
        acc = acc + longint'(mc[j]) * longint'(x);
      end
      expAcc[k] = acc;
    end
    for (int k = 0; k < SN; k++) begin
      mh.push_back(blk[k]);
      void'(mh.pop_front());
    end
  endfunction

  function automatic longint shapeOut(input longint acc, input int w, input int sh, output bit clip);
    longint v, hi, lo;
    hi = (64'sd1 <<< (w-1)) - 64'sd1;
    lo = -hi - 64'sd1;
    v  = acc;
    if (sh > 0) v = (acc + (64'sd1 <<< (sh-1))) >>> sh;
    clip = (v > hi) || (v < lo);
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

  task automatic checkOutputs(input string tag);
    bit satA, satB, satC, clip;
    longint v;
    satA = 1'b0; satB = 1'b0; satC = 1'b0;
    for (int k = 0; k < SN; k++) begin
      v = shapeOut(expAcc[k], 32, 0, clip); satA |= clip;
      chk($sformatf("%s A lane%0d", tag, k), 64'(ifA.dataOut[k*32 +: 32]), 64'(v[31:0]));
      v = shapeOut(expAcc[k], 16, 0, clip); satB |= clip;
      chk($sformatf("%s B lane%0d", tag, k), 64'(ifB.dataOut[k*16 +: 16]), 64'(v[15:0]));
      v = shapeOut(expAcc[k], 32, 1, clip); satC |= clip;
      chk($sformatf("%s C lane%0d", tag, k), 64'(ifC.dataOut[k*32 +: 32]), 64'(v[31:0]));
    end
    chk({tag, " A sat"}, 64'(ifA.satOut), 64'(satA));
    chk({tag, " B sat"}, 64'(ifB.satOut), 64'(satB));
    chk({tag, " C sat"}, 64'(ifC.satOut), 64'(satC));
  endtask

  task automatic writeCoef(input int addr, input logic [SW-1:0] val);
    coefWrIn = 1'b1; coefAddrIn = 3'(addr); coefDataIn = val;
    step();
    coefWrIn = 1'b0;
    mc[addr] = int'($signed(val));
  endtask

  // Drives the accept edge; startIn is left as is so streaming callers can hold it.
  task automatic startBlock(input bit clr, input bit wr, input int addr, input logic [SW-1:0] val);
    if (wr) mc[addr] = int'($signed(val));
    modelBlock(clr);
    for (int k = 0; k < SN; k++) dataIn[k*SW +: SW] = blk[k][SW-1:0];
    startIn = 1'b1; clearHistIn = clr; coefWrIn = wr; coefAddrIn = 3'(addr); coefDataIn = val;
    step();
    clearHistIn = 1'b0; coefWrIn = 1'b0;
    chk("busy after accept", 64'(ifA.busyOut), 64'd1);
    chk("no done at accept", 64'(ifA.doneOut), 64'd0);
  endtask

  task automatic finishBlock(input string tag, input int expSteps);
    int n;
    n = 0;
    while (ifA.doneOut !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(expSteps));
    chk({tag, " busy at done"}, 64'(ifA.busyOut), 64'd0);
    chk({tag, " B done"}, 64'(ifB.doneOut), 64'd1);
    chk({tag, " C done"}, 64'(ifC.doneOut), 64'd1);
    checkOutputs(tag);
  endtask

  task automatic runBlock(input string tag, input bit clr);
    startBlock(clr, 1'b0, 0, '0);
    startIn = 1'b0;
    finishBlock(tag, G + 1);
    step();
    chk({tag, " done drops"}, 64'(ifA.doneOut), 64'd0);
  endtask

  task automatic checkCleared(input string tag);
    chk({tag, " busy"}, 64'(ifA.busyOut), 64'd0);
    chk({tag, " done"}, 64'(ifA.doneOut), 64'd0);
    chk({tag, " reject"}, 64'(ifA.coefRejectOut), 64'd0);
    chk({tag, " A sat"}, 64'(ifA.satOut), 64'd0);
    chk({tag, " B sat"}, 64'(ifB.satOut), 64'd0);
    chk({tag, " A data"}, 64'(ifA.dataOut[63:0]) | 64'(ifA.dataOut[127:64]), 64'd0);
    chk({tag, " B data"}, 64'(ifB.dataOut), 64'd0);
    chk({tag, " C data"}, 64'(ifC.dataOut[63:0]) | 64'(ifC.dataOut[127:64]), 64'd0);
  endtask

  task automatic randomBlock();
    for (int k = 0; k < SN; k++) blk[k] = int'($signed(16'($urandom)));
  endtask

  initial begin
    rst = 1'b1; startIn = 1'b0; coefWrIn = 1'b0; clearHistIn = 1'b0;
    dataIn = '0; coefAddrIn = '0; coefDataIn = '0;
    modelReset();
    step(); step();
    rst = 1'b0;
    checkCleared("reset");

    // Impulse through c[j]=j+1, then the tail spills into the next block.
    for (int j = 0; j < TAPS; j++) writeCoef(j, 16'(j + 1));
    chk("no reject in idle", 64'(ifA.coefRejectOut), 64'd0);
    blk = '{1, 0, 0, 0};
    runBlock("impulse", 1'b0);
    blk = '{0, 0, 0, 0};
    runBlock("tail", 1'b0);
    runBlock("flushed", 1'b0);

    // Full-scale positive then negative coefficients.
    for (int j = 0; j < TAPS; j++) writeCoef(j, 16'h7FFF);
    blk = '{32767, 32767, 32767, 32767};
    runBlock("satpos1", 1'b0);
    runBlock("satpos2", 1'b0);
    for (int j = 0; j < TAPS; j++) writeCoef(j, 16'h8000);
    runBlock("satneg", 1'b0);

    // Rounding with a pass-through tap.
    writeCoef(0, 16'd1);
    for (int j = 1; j < TAPS; j++) writeCoef(j, 16'd0);
    blk = '{3, -3, 5, -5};
    runBlock("round", 1'b1);

    // Coefficient write while busy is dropped and flagged for one cycle.
    for (int j = 0; j < TAPS; j++) writeCoef(j, 16'(j + 1));
    blk = '{1, 0, 0, 0};
    startBlock(1'b1, 1'b0, 0, '0);
    startIn = 1'b0;
    coefWrIn = 1'b1; coefAddrIn = 3'd0; coefDataIn = 16'd9;
    step();
    coefWrIn = 1'b0;
    chk("reject pulse", 64'(ifA.coefRejectOut), 64'd1);
    step();
    chk("reject clears", 64'(ifA.coefRejectOut), 64'd0);
    finishBlock("busy write", G - 1);
    step();
    runBlock("impulse after reject", 1'b1);

    // Back-to-back blocks with startIn held high.
    for (int b = 0; b < 4; b++) begin
      randomBlock();
      startBlock(1'b0, 1'b0, 0, '0);
      finishBlock($sformatf("stream%0d", b), G + 1);
    end
    startIn = 1'b0;
    step();
    chk("stream idle", 64'(ifA.busyOut), 64'd0);

    // Reset at E1 aborts the block and clears the coefficient bank.
    blk = '{1, 0, 0, 0};
    startBlock(1'b0, 1'b0, 0, '0);
    startIn = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    modelReset();
    checkCleared("abort");
    runBlock("impulse after reset", 1'b0);

    // Clearing history between blocks kills the tail.
    for (int j = 0; j < TAPS; j++) writeCoef(j, 16'(j + 1));
    blk = '{1, 0, 0, 0};
    runBlock("impulse2", 1'b0);
    clearHistIn = 1'b1;
    step();
    clearHistIn = 1'b0;
    foreach (mh[i]) mh[i] = 0;
    blk = '{0, 0, 0, 0};
    runBlock("cleared tail", 1'b0);

    // Random coefficients and data, with coincident writes and clears at accept.
    for (int j = 0; j < TAPS; j++) writeCoef(j, 16'($urandom));
    for (int r = 0; r < 8; r++) begin
      randomBlock();
      startBlock(1'($urandom), 1'($urandom), int'($urandom_range(TAPS - 1, 0)), 16'($urandom));
      startIn = 1'b0;
      finishBlock($sformatf("rand%0d", r), G + 1);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
